weight_ram_ctrl: RTL and testbench
==================================

Name: weight_ram_ctrl

Overview:
Sequencer for the row-wide weight RAM (NCOL rows of NROW×BITWIDTH bits).
- LOAD: assembles a stream of BITWIDTH-bit words into full rows and writes them to RAM rows 0..NCOL-1.
- RUN: sweeps the read address 0..NCOL-1 and flags each row as it appears on the RAM output for the downstream MAC array.
- The two modes are mutually exclusive, so the RAM never sees write and read in the same cycle.

Parameters:
NROW, 256, words per RAM row; power of 2, ≥2
NCOL, 256, RAM depth in rows; power of 2, ≥2
BITWIDTH, 18, bits per weight word
Derived: ROW_W = NROW*BITWIDTH; AW = log2(NCOL); WW = log2(NROW)

Ports:
clk  in  1  clock; all controller logic on posedge
reset  in  1  reset, synchronous, active-high
load_start  in  1  begin a LOAD; honoured only in IDLE
in_valid  in  1  weight word valid
in_data  in  BITWIDTH  weight word
in_ready  out  1  word accepted when in_valid&in_ready
load_done  out  1  one-cycle pulse after last row is written
run_start  in  1  begin a RUN; honoured only in IDLE
step_en  in  1  consumer advance enable during RUN
row_valid  out  1  RAM rowOut holds a requested row this cycle
row_idx  out  AW  index of the row flagged by row_valid
row_last  out  1  row_valid for row NCOL-1
run_done  out  1  one-cycle pulse after last row is flagged
busy  out  1  state != IDLE
start_err  out  1  one-cycle pulse: load_start or run_start seen while busy
ram_we  out  1  RAM write enable
ram_addr_in  out  AW  RAM write address
ram_row_in  out  ROW_W  RAM write data
ram_addr_out  out  AW  RAM read address
ram_reset  out  1  RAM reset; equals reset, combinational

Behaviour:
- States: IDLE, FILL, WRITE, RUN, DRAIN.
- Reset values: state=IDLE; all counters 0.
  - Outputs: in_ready, load_done, row_valid, row_last, run_done, start_err, ram_we all 0.
  - Buses: ram_addr_in, ram_addr_out, row_idx = 0; ram_row_in = 0.
- IDLE:
  - load_start → FILL, with word_cnt=0 and row_cnt=0.
  - else run_start → RUN, with ram_addr_out=0.
  - If both are asserted, load wins; no start_err.
- FILL:
  - in_ready=1.
  - Each accepted word is written to ram_row_in[word_cnt*BITWIDTH +: BITWIDTH]; word 0 is the LSBs.
  - word_cnt wraps at NROW.
  - Acceptance of word NROW-1 → WRITE.
- WRITE, exactly one cycle:
  - ram_we=1, ram_addr_in=row_cnt, in_ready=0. The RAM captures the row on the intervening negedge.
  - Then row_cnt+1 → FILL.
  - If row_cnt==NCOL-1 → IDLE, load_done=1 on the same edge, row_cnt wraps to 0.
- RUN:
  - ram_addr_out holds the current column c. When step_en=1, c advances on the posedge.
  - A registered flag pipes (RUN & step_en): row_valid=1 and row_idx=c in the cycle after c was presented. rowOut is updated at the negedge in between, giving a read latency of 1 cycle.
  - step_en=0 holds the address; no row_valid the following cycle.
  - When c==NCOL-1 and step_en=1 → DRAIN, and ram_addr_out stays at NCOL-1.
- DRAIN, one cycle:
  - row_valid=1, row_idx=NCOL-1, row_last=1, run_done=1.
  - Then → IDLE.
- ram_we is 1 only in WRITE; ram_addr_out is never changed while ram_we=1.
- A start seen in any non-IDLE state is ignored and pulses start_err. Inputs that arrive while in FILL never stall.
- in_valid outside FILL is ignored; in_ready=0 there.
- Reset mid-operation:
  - Next posedge → IDLE; counters 0; any partial row is discarded.
  - ram_we drops at that edge; rows already written remain in the RAM.
  - RAM rowOut is zeroed through ram_reset.
- Counter widths: word_cnt is WW bits, row_cnt and c are AW bits. Wrap-around is natural (power-of-2 sizes).

Decomposition:
- Shared package wram_pkg holds:
  - state enum {IDLE, FILL, WRITE, RUN, DRAIN};
  - log2 constant function;
  - default NROW/NCOL/BITWIDTH constants.
- One sub-module, wram_row_packer: word_cnt plus the row assembly register, with controls clear, push, full.
- FSM, address counters and RUN pipe flag stay in the top.

Test Plan:
1. Full load (NROW=4, NCOL=4, BITWIDTH=18), words 0..15 with in_valid held high:
   - 4 WRITE cycles at addr 0..3; row 0 = {3,2,1,0};
   - in_ready low 1 cycle after every 4th word; load_done pulse after the 16th word + 1 cycle.
2. Full run after (1), step_en=1:
   - row_valid for 4 consecutive cycles starting 1 cycle after run_start acceptance;
   - row_idx 0..3 with RAM data matching; row_last and run_done on idx 3.
3. RUN with step_en toggled 1,0,1,1,0,1:
   - no row_valid gaps beyond those stalls; no duplicate or skipped row_idx.
4. load_start and run_start asserted together in IDLE → LOAD entered, no start_err; run_start mid-LOAD → start_err pulse, LOAD unaffected.
5. reset asserted after 6 of 16 words → IDLE next cycle, ram_we=0, busy=0; a reloaded row 1 holds only new words.
6. in_valid deasserted randomly in FILL → row contents unchanged versus the contiguous stream; ram_we never overlaps a changing ram_addr_out.

Source files
------------

// File: rtl/wram_pkg.sv
// Shared definitions for the weight RAM controller: FSM state encoding,
// default geometry and a constant log2 helper for deriving address widths.
package wram_pkg;

    localparam int DEF_NROW     = 256;
    localparam int DEF_NCOL     = 256;
    localparam int DEF_BITWIDTH = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WRITE = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } wram_state_t;

    // Ceiling log2, usable in parameter declarations.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wram_row_packer.sv
// Assembles BITWIDTH-bit words into one RAM row; word 0 lands in the LSBs.
// 'full' flags the push that completes the row, after which the word
// counter has naturally wrapped back to zero for the next row.
module wram_row_packer
    import wram_pkg::*;
#(
    parameter  int NROW     = DEF_NROW,
    parameter  int BITWIDTH = DEF_BITWIDTH,
    localparam int ROW_W    = NROW * BITWIDTH,
    localparam int WW       = clog2_f(NROW)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                push,
    input  logic [BITWIDTH-1:0] word,
    output logic [ROW_W-1:0]    row,
    output logic                full
);

    localparam logic [WW-1:0] LAST_WORD = {WW{1'b1}};

    logic [WW-1:0]    word_cnt_r;
    logic [ROW_W-1:0] row_r;

    // Word counter and row assembly register; clear starts a fresh load.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_cnt_r <= {WW{1'b0}};
            row_r      <= {ROW_W{1'b0}};
        end else if (push) begin
            word_cnt_r <= word_cnt_r + WW'(1'b1);
            row_r[int'(word_cnt_r) * BITWIDTH +: BITWIDTH] <= word;
        end
    end

    assign full = push & (word_cnt_r == LAST_WORD);
    assign row  = row_r;

endmodule

// File: rtl/weight_ram_ctrl.sv
// Weight RAM sequencer. LOAD packs the input word stream into rows and
// writes rows 0..NCOL-1; RUN sweeps the read address and flags each row
// one cycle after its address was presented (RAM reads on the negedge).
// LOAD and RUN are exclusive, so the read address never moves during a write.
module weight_ram_ctrl
    import wram_pkg::*;
#(
    parameter  int NROW     = DEF_NROW,
    parameter  int NCOL     = DEF_NCOL,
    parameter  int BITWIDTH = DEF_BITWIDTH,
    localparam int ROW_W    = NROW * BITWIDTH,
    localparam int AW       = clog2_f(NCOL)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic                in_valid,
    input  logic [BITWIDTH-1:0] in_data,
    output logic                in_ready,
    output logic                load_done,
    input  logic                run_start,
    input  logic                step_en,
    output logic                row_valid,
    output logic [AW-1:0]       row_idx,
    output logic                row_last,
    output logic                run_done,
    output logic                busy,
    output logic                start_err,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr_in,
    output logic [ROW_W-1:0]    ram_row_in,
    output logic [AW-1:0]       ram_addr_out,
    output logic                ram_reset
);

    localparam logic [AW-1:0] LAST_COL = {AW{1'b1}};

    wram_state_t      state_r;
    logic             in_ready_r;
    logic             load_done_r;
    logic             row_valid_r;
    logic             row_last_r;
    logic             run_done_r;
    logic             busy_r;
    logic             start_err_r;
    logic             ram_we_r;
    logic [AW-1:0]    row_cnt_r;
    logic [AW-1:0]    col_r;
    logic [AW-1:0]    ram_addr_in_r;
    logic [AW-1:0]    row_idx_r;

    logic             clear_s;
    logic             push_s;
    logic             full_s;
    logic [ROW_W-1:0] row_s;

    assign clear_s = (state_r == IDLE) & load_start;
    assign push_s  = (state_r == FILL) & in_valid & in_ready_r;

    wram_row_packer #(
        .NROW     (NROW),
        .BITWIDTH (BITWIDTH)
    ) u_packer (
        .clk   (clk),
        .reset (reset),
        .clear (clear_s),
        .push  (push_s),
        .word  (in_data),
        .row   (row_s),
        .full  (full_s)
    );

    // Mode FSM with registered handshake, status and RAM control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            in_ready_r    <= 1'b0;
            load_done_r   <= 1'b0;
            row_valid_r   <= 1'b0;
            row_last_r    <= 1'b0;
            run_done_r    <= 1'b0;
            busy_r        <= 1'b0;
            start_err_r   <= 1'b0;
            ram_we_r      <= 1'b0;
            row_cnt_r     <= {AW{1'b0}};
            col_r         <= {AW{1'b0}};
            ram_addr_in_r <= {AW{1'b0}};
            row_idx_r     <= {AW{1'b0}};
        end else begin
            load_done_r <= 1'b0;
            run_done_r  <= 1'b0;
            row_last_r  <= 1'b0;
            row_valid_r <= 1'b0;
            ram_we_r    <= 1'b0;
            start_err_r <= (state_r != IDLE) & (load_start | run_start);
            case (state_r)
                IDLE: begin
                    if (load_start) begin
                        state_r    <= FILL;
                        row_cnt_r  <= {AW{1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else if (run_start) begin
                        state_r <= RUN;
                        col_r   <= {AW{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FILL: begin
                    if (full_s) begin
                        state_r       <= WRITE;
                        in_ready_r    <= 1'b0;
                        ram_we_r      <= 1'b1;
                        ram_addr_in_r <= row_cnt_r;
                    end else begin
                        state_r <= FILL;
                    end
                end
                WRITE: begin
                    row_cnt_r <= row_cnt_r + AW'(1'b1);
                    if (row_cnt_r == LAST_COL) begin
                        state_r     <= IDLE;
                        load_done_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r    <= FILL;
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    row_valid_r <= step_en;
                    if (step_en) begin
                        row_idx_r <= col_r;
                        if (col_r == LAST_COL) begin
                            state_r    <= DRAIN;
                            row_last_r <= 1'b1;
                            run_done_r <= 1'b1;
                        end else begin
                            col_r <= col_r + AW'(1'b1);
                        end
                    end
                end
                DRAIN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign load_done    = load_done_r;
    assign row_valid    = row_valid_r;
    assign row_idx      = row_idx_r;
    assign row_last     = row_last_r;
    assign run_done     = run_done_r;
    assign busy         = busy_r;
    assign start_err    = start_err_r;
    assign ram_we       = ram_we_r;
    assign ram_addr_in  = ram_addr_in_r;
    assign ram_row_in   = row_s;
    assign ram_addr_out = col_r;
    assign ram_reset    = reset;

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Bench for weight_ram_ctrl with a small geometry. A behavioural RAM sits
// on the RAM ports; expected row contents are built from the word streams.
module tb_weight_ram_ctrl;

    localparam int NROW   = 4;
    localparam int NCOL   = 4;
    localparam int BW     = 18;
    localparam int ROW_W  = NROW * BW;
    localparam int AW     = 2;
    localparam int NWORDS = NROW * NCOL;

    logic             clk;
    logic             reset;
    logic             load_start;
    logic             in_valid;
    logic [BW-1:0]    in_data;
    logic             in_ready;
    logic             load_done;
    logic             run_start;
    logic             step_en;
    logic             row_valid;
    logic [AW-1:0]    row_idx;
    logic             row_last;
    logic             run_done;
    logic             busy;
    logic             start_err;
    logic             ram_we;
    logic [AW-1:0]    ram_addr_in;
    logic [ROW_W-1:0] ram_row_in;
    logic [AW-1:0]    ram_addr_out;
    logic             ram_reset;

    logic [ROW_W-1:0] ram_mem [NCOL];
    logic [ROW_W-1:0] ram_rowout;

    logic [BW-1:0]    words   [NWORDS];
    logic [ROW_W-1:0] exp_mem [NCOL];
    logic [AW-1:0]    wr_addr [$];
    logic [ROW_W-1:0] wr_data [$];
    logic [AW-1:0]    prev_addr_out;
    bit               pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    int n_chk  = 0;
    int n_pass = 0;
    int ld_cyc;
    int ld_zeros;

    weight_ram_ctrl #(
        .NROW     (NROW),
        .NCOL     (NCOL),
        .BITWIDTH (BW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .load_done    (load_done),
        .run_start    (run_start),
        .step_en      (step_en),
        .row_valid    (row_valid),
        .row_idx      (row_idx),
        .row_last     (row_last),
        .run_done     (run_done),
        .busy         (busy),
        .start_err    (start_err),
        .ram_we       (ram_we),
        .ram_addr_in  (ram_addr_in),
        .ram_row_in   (ram_row_in),
        .ram_addr_out (ram_addr_out),
        .ram_reset    (ram_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural row RAM: write and registered read on the negedge.
    always @(negedge clk) begin
        if (ram_reset) begin
            ram_rowout <= '0;
        end else begin
            if (ram_we) ram_mem[ram_addr_in] <= ram_row_in;
            ram_rowout <= ram_mem[ram_addr_out];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ram_we === 1'b1) begin
            chk("we_addr_out_stable", ram_addr_out, prev_addr_out);
            wr_addr.push_back(ram_addr_in);
            wr_data.push_back(ram_row_in);
        end
        prev_addr_out = ram_addr_out;
    endtask

    task automatic build_exp();
        for (int r = 0; r < NCOL; r++) begin
            exp_mem[r] = '0;
            for (int k = 0; k < NROW; k++)
                exp_mem[r] = exp_mem[r] | (ROW_W'(words[r * NROW + k]) << (k * BW));
        end
    endtask

    task automatic do_load(input bit rnd_valid, input bit both, input int err_at,
                           input int abort_at, output int cyc, output int zeros);
        int  widx;
        bit  acc;
        bit  rs;
        wr_addr.delete();
        wr_data.delete();
        load_start = 1'b1;
        run_start  = both;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        chk("ld_busy", busy, 1'b1);
        chk("ld_ready", in_ready, 1'b1);
        chk("ld_no_start_err", start_err, 1'b0);
        widx  = 0;
        cyc   = 0;
        zeros = 0;
        while (widx < NWORDS && cyc < 1000) begin
            if (abort_at >= 0 && widx == abort_at) break;
            in_valid  = rnd_valid ? 1'($urandom_range(1, 0)) : 1'b1;
            in_data   = words[widx];
            rs        = (cyc == err_at);
            run_start = rs;
            acc       = in_valid & in_ready;
            if (!in_ready) zeros++;
            tick();
            chk("ld_start_err", start_err, rs);
            if (acc) widx++;
            cyc++;
        end
        in_valid  = 1'b0;
        run_start = 1'b0;
        if (abort_at < 0) begin
            chk("ld_words_accepted", widx, NWORDS);
            chk("ld_last_we", ram_we, 1'b1);
            tick();
            chk("ld_done_pulse", load_done, 1'b1);
            chk("ld_idle_busy", busy, 1'b0);
            tick();
            chk("ld_done_clear", load_done, 1'b0);
            build_exp();
            chk("ld_write_count", wr_addr.size(), NCOL);
            for (int r = 0; r < NCOL && r < wr_addr.size(); r++) begin
                chk("ld_write_addr", wr_addr[r], r);
                chk("ld_write_data", wr_data[r], exp_mem[r]);
            end
        end
    endtask

    task automatic do_run(input int mode, input int err_at);
        int steps;
        int cyc;
        bit s;
        bit ls;
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("run_busy", busy, 1'b1);
        chk("run_in_ready", in_ready, 1'b0);
        chk("run_first_quiet", row_valid, 1'b0);
        steps = 0;
        cyc   = 0;
        while (steps < NCOL && cyc < 1000) begin
            if (mode == 0)      s = 1'b1;
            else if (mode == 1) s = (cyc < 6) ? pat[cyc] : 1'b1;
            else                s = 1'($urandom_range(1, 0));
            ls         = (cyc == err_at);
            step_en    = s;
            load_start = ls;
            tick();
            chk("run_row_valid", row_valid, s);
            chk("run_start_err", start_err, ls);
            chk("run_no_we", ram_we, 1'b0);
            if (s) begin
                chk("run_row_idx", row_idx, steps);
                chk("run_row_data", ram_rowout, exp_mem[steps]);
                chk("run_row_last", row_last, steps == NCOL - 1);
                chk("run_done_flag", run_done, steps == NCOL - 1);
                steps++;
            end else begin
                chk("run_stall_done", run_done, 1'b0);
            end
            cyc++;
        end
        step_en    = 1'b0;
        load_start = 1'b0;
        chk("run_steps", steps, NCOL);
        tick();
        chk("run_end_busy", busy, 1'b0);
        chk("run_end_valid", row_valid, 1'b0);
        chk("run_end_done", run_done, 1'b0);
        chk("run_no_load", in_ready, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        run_start  = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        step_en    = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_load_done", load_done, 1'b0);
        chk("rst_row_valid", row_valid, 1'b0);
        chk("rst_row_last", row_last, 1'b0);
        chk("rst_run_done", run_done, 1'b0);
        chk("rst_start_err", start_err, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr_in", ram_addr_in, 0);
        chk("rst_addr_out", ram_addr_out, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_row_in", ram_row_in, 0);
        chk("rst_ram_reset", ram_reset, 1'b1);
        chk("rst_rowout", ram_rowout, 0);
        reset = 1'b0;
        tick();
        chk("ram_reset_low", ram_reset, 1'b0);

        // Sequential words with valid held high.
        for (int i = 0; i < NWORDS; i++) words[i] = BW'(i);
        do_load(1'b0, 1'b0, -1, -1, ld_cyc, ld_zeros);
        chk("ld_cycles", ld_cyc, NWORDS + NCOL - 1);
        chk("ld_ready_gaps", ld_zeros, NCOL - 1);
        if (wr_data.size() > 0)
            chk("ld_row0_const", wr_data[0], {18'd3, 18'd2, 18'd1, 18'd0});

        do_run(0, -1);
        do_run(1, -1);

        // Simultaneous starts, then run_start mid-load.
        for (int i = 0; i < NWORDS; i++) words[i] = BW'($urandom);
        do_load(1'b0, 1'b1, 5, -1, ld_cyc, ld_zeros);
        do_run(0, 2);

        // Reset after 6 words, then a full reload with fresh data.
        for (int i = 0; i < NWORDS; i++) words[i] = BW'($urandom);
        do_load(1'b0, 1'b0, -1, 6, ld_cyc, ld_zeros);
        reset = 1'b1;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_we", ram_we, 1'b0);
        chk("abort_ready", in_ready, 1'b0);
        chk("abort_rowout", ram_rowout, 0);
        reset = 1'b0;
        tick();
        chk("abort_idle", busy, 1'b0);
        for (int i = 0; i < NWORDS; i++) words[i] = BW'($urandom);
        do_load(1'b1, 1'b0, -1, -1, ld_cyc, ld_zeros);
        do_run(2, 1);

        // Random valid gaps and random stepping.
        for (int i = 0; i < NWORDS; i++) words[i] = BW'($urandom);
        do_load(1'b1, 1'b0, 7, -1, ld_cyc, ld_zeros);
        do_run(2, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
